// File: rtl/password_match_checker.sv
// Constant-time password checker: walks PW_LEN words of ROM and RAM on one shared
// address bus, issues one verdict per attempt and locks out after repeated failures.
module password_match_checker #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                PW_LEN      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                RD_LAT      = 1,
    parameter int                MAX_FAILS   = 3,
    parameter int                LOCK_CYCLES = 1000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [DATA_W-1:0]                rom_data,
    input  logic [DATA_W-1:0]                ram_data,
    output logic                             busy,
    output logic                             done,
    output logic                             match,
    output logic                             locked,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int IDX_W  = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
    localparam int LAT_W  = $clog2(RD_LAT + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int CNT_W  = $clog2(MAX_FAILS + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PW_LEN - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT);
    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FAIL_MAX  = CNT_W'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOCK
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   word_idx;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LOCK_W-1:0]  lock_cnt;
    logic               mismatch;
    logic               scan_mismatch;
    logic [CNT_W-1:0]   fail_next;

    // NOTE: every variable gets a value on every pass through always_comb, so no latch is inferred.
    always_comb begin
        scan_mismatch = mismatch | (rom_data != ram_data);
        fail_next     = (fail_count == FAIL_MAX) ? FAIL_MAX : fail_count + CNT_W'(1);
    end

    // NOTE: state is updated with <= only, so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
            locked     <= 1'b0;
            fail_count <= '0;
            mem_addr   <= BASE_ADDR;
            word_idx   <= '0;
            lat_cnt    <= '0;
            lock_cnt   <= '0;
            mismatch   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        word_idx <= '0;
                        lat_cnt  <= '0;
                        mem_addr <= BASE_ADDR;
                        mismatch <= 1'b0;
                    end
                end

                FETCH: begin
                    // Each address is held until its data has crossed the read latency;
                    // all words are compared regardless of earlier mismatches.
                    if (lat_cnt != LAT_LAST) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end else begin
                        lat_cnt  <= '0;
                        mismatch <= scan_mismatch;
                        if (word_idx != IDX_LAST) begin
                            word_idx <= word_idx + IDX_W'(1);
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end else begin
                            done     <= 1'b1;
                            match    <= ~scan_mismatch;
                            busy     <= 1'b0;
                            mem_addr <= BASE_ADDR;
                            if (!scan_mismatch) begin
                                fail_count <= '0;
                                state      <= IDLE;
                            end else begin
                                fail_count <= fail_next;
                                if (fail_next == FAIL_MAX) begin
                                    locked   <= 1'b1;
                                    lock_cnt <= LOCK_INIT;
                                    state    <= LOCK;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                end

                LOCK: begin
                    if (lock_cnt == '0) begin
                        locked     <= 1'b0;
                        fail_count <= '0;
                        state      <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LOCK_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
